// File: rtl/buffer_frame_reader_pkg.sv
// Shared definitions for the buffer frame reader: default parameters and FSM state encoding.
package buffer_frame_reader_pkg;

    localparam int         DEF_DATA_WIDTH = 9;
    localparam int         DEF_FRAME_LEN  = 8;
    localparam logic [7:0] DEF_SYNC_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_FETCH,
        ST_HI,
        ST_LO,
        ST_CSUM
    } state_t;

endpackage

// File: rtl/buffer_frame_reader.sv
// Pops words from the sample Buffer and sends them as SYNC / hi,lo byte pairs / XOR checksum
// frames over a valid/ready byte link. Every output comes straight from a register.
module buffer_frame_reader
    import buffer_frame_reader_pkg::*;
#(
    parameter int         DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int         FRAME_LEN  = DEF_FRAME_LEN,
    parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] buf_data,
    input  logic                  buf_valid,
    output logic                  buf_read,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_LEN - 1);

    state_t           r_state,      w_state;
    logic [7:0]       r_word_lo,    w_word_lo;
    logic [CNT_W-1:0] r_word_cnt,   w_word_cnt;
    logic [7:0]       r_csum,       w_csum;
    logic             r_buf_read,   w_buf_read;
    logic [7:0]       r_tx_data,    w_tx_data;
    logic             r_tx_valid,   w_tx_valid;
    logic             r_busy,       w_busy;
    logic             r_frame_done, w_frame_done;

    logic [15:0]      w_word16;
    logic             w_accept;
    logic [7:0]       w_csum_acc;

    // Only the low byte needs to be held; the high byte is launched the moment the word is popped.
    assign w_word16   = 16'(buf_data);
    assign w_accept   = r_tx_valid && tx_ready;
    assign w_csum_acc = r_csum ^ r_tx_data;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        w_state      = r_state;
        w_word_lo    = r_word_lo;
        w_word_cnt   = r_word_cnt;
        w_csum       = r_csum;
        w_buf_read   = 1'b0;
        w_tx_data    = r_tx_data;
        w_tx_valid   = r_tx_valid;
        w_busy       = r_busy;
        w_frame_done = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (buf_valid) begin
                    w_state    = ST_SYNC;
                    w_tx_data  = SYNC_BYTE;
                    w_tx_valid = 1'b1;
                    w_busy     = 1'b1;
                    w_csum     = '0;
                    w_word_cnt = '0;
                end
            end
            ST_SYNC: begin
                if (w_accept) begin
                    w_state    = ST_FETCH;
                    w_tx_valid = 1'b0;
                end
            end
            ST_FETCH: begin
                w_tx_valid = 1'b0;
                if (buf_valid) begin
                    w_state    = ST_HI;
                    w_word_lo  = w_word16[7:0];
                    w_buf_read = 1'b1;
                    w_tx_data  = w_word16[15:8];
                    w_tx_valid = 1'b1;
                end
            end
            ST_HI: begin
                if (w_accept) begin
                    w_state   = ST_LO;
                    w_csum    = w_csum_acc;
                    w_tx_data = r_word_lo;
                end
            end
            ST_LO: begin
                if (w_accept) begin
                    w_csum     = w_csum_acc;
                    w_word_cnt = r_word_cnt + CNT_W'(1);
                    if (r_word_cnt == LAST_WORD) begin
                        w_state   = ST_CSUM;
                        w_tx_data = w_csum_acc;
                    end else begin
                        w_state    = ST_FETCH;
                        w_tx_valid = 1'b0;
                    end
                end
            end
            ST_CSUM: begin
                if (w_accept) begin
                    w_state      = ST_IDLE;
                    w_tx_valid   = 1'b0;
                    w_busy       = 1'b0;
                    w_frame_done = 1'b1;
                end
            end
            default: begin
                w_state    = ST_IDLE;
                w_tx_valid = 1'b0;
                w_busy     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_word_lo    <= '0;
            r_word_cnt   <= '0;
            r_csum       <= '0;
            r_buf_read   <= 1'b0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            r_state      <= w_state;
            r_word_lo    <= w_word_lo;
            r_word_cnt   <= w_word_cnt;
            r_csum       <= w_csum;
            r_buf_read   <= w_buf_read;
            r_tx_data    <= w_tx_data;
            r_tx_valid   <= w_tx_valid;
            r_busy       <= w_busy;
            r_frame_done <= w_frame_done;
        end
    end

    assign buf_read   = r_buf_read;
    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_buffer_frame_reader.sv
// Scoreboard bench for buffer_frame_reader: a queue-backed Buffer model feeds words, a monitor
// checks every accepted byte, frame_done timing, tx hold during stalls and pop spacing.
module tb_buffer_frame_reader;

    localparam int DW = 9;
    localparam int FL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] buf_data = '0;
    logic          buf_valid = 1'b0;
    logic          buf_read;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic          frame_done;

    typedef struct {
        logic [7:0] b;
        bit         first;
        bit         last;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] buf_q[$];

    int   checks = 0;
    int   errors = 0;
    int   rd_cnt = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   t_sync = 0;
    int   t_done = 0;
    bit   toggle_mode = 1'b0;
    bit   stalled = 1'b0;
    bit   pend_done = 1'b0;
    bit   prev_rd = 1'b0;
    logic [7:0] held = '0;
    exp_t e;

    always #5 clk = ~clk;

    buffer_frame_reader #(
        .DATA_WIDTH(DW),
        .FRAME_LEN (FL),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .buf_data  (buf_data),
        .buf_valid (buf_valid),
        .buf_read  (buf_read),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Buffer model: registered head word, popped on the edge after buf_read is seen.
    always @(negedge clk) begin
        if (buf_read && buf_q.size() > 0) buf_q.delete(0);
        buf_valid = (buf_q.size() != 0);
        buf_data  = buf_valid ? buf_q[0] : '0;
    end

    always @(negedge clk) if (toggle_mode) tx_ready = ~tx_ready;

    // Monitor: samples between edges, so what it sees is what the next posedge will act on.
    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!rst) begin
                stalled   = 1'b0;
                pend_done = 1'b0;
                prev_rd   = 1'b0;
            end else begin
                if (pend_done) begin
                    check("frame_done_pulse", frame_done, 1);
                    pend_done = 1'b0;
                    if (frame_done) begin
                        done_cnt++;
                        t_done = cyc;
                    end
                end else if (frame_done) begin
                    check("frame_done_spurious", frame_done, 0);
                end
                if (buf_read) begin
                    rd_cnt++;
                    check("buf_read_consecutive", prev_rd, 0);
                end
                prev_rd = buf_read;
                if (stalled) begin
                    check("tx_valid_held", tx_valid, 1);
                    check("tx_data_stable", tx_data, held);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", tx_data, e.b);
                        if (e.first) t_sync = cyc;
                        if (e.last)  pend_done = 1'b1;
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = tx_valid;
                    held    = tx_data;
                end
            end
        end
    end

    task automatic expect_frame(input logic [8:0] w0, input logic [8:0] w1, input logic [7:0] cs);
        exp_q.push_back('{8'hA5, 1'b1, 1'b0});
        exp_q.push_back('{{7'b0, w0[8]}, 1'b0, 1'b0});
        exp_q.push_back('{w0[7:0], 1'b0, 1'b0});
        exp_q.push_back('{{7'b0, w1[8]}, 1'b0, 1'b0});
        exp_q.push_back('{w1[7:0], 1'b0, 1'b0});
        exp_q.push_back('{cs, 1'b0, 1'b1});
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frames_completed", done_cnt, target);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_buf_read"},   buf_read, 0);
        check({tag, "_tx_valid"},   tx_valid, 0);
        check({tag, "_tx_data"},    tx_data, 0);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int  base;
        bit  found;

        // 1: reset with live inputs, then idle with an empty Buffer
        rst = 1'b0;
        @(negedge clk);
        buf_q.push_back(DW'($urandom));
        tx_ready = 1'($urandom_range(0, 1));
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        buf_q.delete();
        repeat (2) @(negedge clk);
        tx_ready = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_tx_valid", tx_valid, 0);
        check("idle_buf_read", buf_read, 0);

        // 2: two-word frame, link always ready
        @(negedge clk);
        rd_cnt = 0;
        base = done_cnt;
        expect_frame(9'h1FF, 9'h023, 8'hDD);
        buf_q.push_back(9'h1FF);
        buf_q.push_back(9'h023);
        wait_frames(base + 1, 200);
        check("t2_pops", rd_cnt, 2);
        check("t2_frame_cycles", t_done - t_sync, 8);

        // 3: same frame with tx_ready toggling every cycle
        @(negedge clk);
        rd_cnt = 0;
        base = done_cnt;
        expect_frame(9'h1FF, 9'h023, 8'hDD);
        buf_q.push_back(9'h1FF);
        buf_q.push_back(9'h023);
        toggle_mode = 1'b1;
        wait_frames(base + 1, 200);
        toggle_mode = 1'b0;
        @(negedge clk);
        tx_ready = 1'b1;
        check("t3_pops", rd_cnt, 2);

        // 4: Buffer runs dry mid-frame, second word arrives 10 cycles later
        @(negedge clk);
        base = done_cnt;
        expect_frame(9'h1FF, 9'h100, 8'hFF);
        buf_q.push_back(9'h1FF);
        repeat (10) @(negedge clk);
        #1;
        check("t4_stall_tx_valid", tx_valid, 0);
        check("t4_stall_busy", busy, 1);
        check("t4_stall_buf_read", buf_read, 0);
        @(negedge clk);
        buf_q.push_back(9'h100);
        wait_frames(base + 1, 200);

        // 5: async reset while the LO byte is on the link
        @(negedge clk);
        exp_q.push_back('{8'hA5, 1'b1, 1'b0});
        exp_q.push_back('{8'h01, 1'b0, 1'b0});
        buf_q.push_back(9'h1FF);
        buf_q.push_back(9'h023);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk);
            #1;
            if (tx_valid && tx_data == 8'hFF) found = 1'b1;
        end
        check("t5_reached_lo", found, 1);
        rst = 1'b0;
        #1;
        check_all_zero("t5_async");
        check("t5_partial_consumed", exp_q.size(), 0);
        base = done_cnt;
        expect_frame(9'h023, 9'h0AB, 8'h88);
        buf_q.push_back(9'h0AB);
        @(negedge clk);
        rst = 1'b1;
        wait_frames(base + 1, 200);

        // 6: three frames queued back to back
        @(negedge clk);
        rd_cnt = 0;
        base = done_cnt;
        expect_frame(9'h155, 9'h0AA, 8'hFE);
        expect_frame(9'h012, 9'h134, 8'h27);
        expect_frame(9'h1C3, 9'h03C, 8'hFE);
        buf_q.push_back(9'h155);
        buf_q.push_back(9'h0AA);
        buf_q.push_back(9'h012);
        buf_q.push_back(9'h134);
        buf_q.push_back(9'h1C3);
        buf_q.push_back(9'h03C);
        wait_frames(base + 3, 500);
        check("t6_pops", rd_cnt, 6);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("buffer_drained", buf_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
